// File: rtl/cpu_phase_ctrl.sv
// cpu_phase_ctrl: instruction phase sequencer (FETCH/DECODE/EXEC/MEM/WB)
// with halt/run control and MEM bus-timeout trap.
// Optional feature macro: PHASE_CTRL_PERF_EN enables the 32-bit cycle and
// retired-instruction counters; when undefined both outputs are tied to 0.
module cpu_phase_ctrl #(
  parameter int RESET_HOLD_CYC = 4,
  parameter int MEM_TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        halt_req,
  input  logic        is_muldiv,
  input  logic        is_mem,
  input  logic        alu_complete,
  input  logic        mem_ack,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        alu_start,
  output logic        mem_req,
  output logic        commit,
  output logic [2:0]  state,
  output logic        busy,
  output logic        bus_err,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_RST_HOLD = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_EXEC     = 3'd3,
    S_MEM      = 3'd4,
    S_WB       = 3'd5,
    S_HALT     = 3'd6,
    S_ERR      = 3'd7
  } state_t;

  // Last count value before leaving RST_HOLD / before a MEM timeout fires.
  localparam logic [7:0] HOLD_LAST    = 8'(RESET_HOLD_CYC - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_reg, state_next;
  logic [7:0] hold_cnt_reg, hold_cnt_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       fetch_en_reg, decode_en_reg, alu_start_reg, mem_req_reg;
  logic       commit_reg, busy_reg, bus_err_reg;
  logic       exec_done;

  // Next-state logic; alu_start_reg doubles as the "first EXEC cycle" flag
  // so a stale alu_complete from the previous op is discarded.
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    wait_cnt_next = wait_cnt_reg;
    exec_done     = !is_muldiv || (!alu_start_reg && alu_complete);
    case (state_reg)
      S_RST_HOLD: begin
        if (hold_cnt_reg == HOLD_LAST) state_next = run ? S_FETCH : S_HALT;
        else                           hold_cnt_next = hold_cnt_reg + 8'd1;
      end
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        if (exec_done) begin
          state_next    = is_mem ? S_MEM : S_WB;
          wait_cnt_next = 8'd0;
        end
      end
      S_MEM: begin
        // An ack on the final allowed cycle takes priority over the timeout.
        if (mem_ack)                          state_next = S_WB;
        else if (wait_cnt_reg == TIMEOUT_LAST) state_next = S_ERR;
        else                                   wait_cnt_next = wait_cnt_reg + 8'd1;
      end
      S_WB:     state_next = (halt_req || !run) ? S_HALT : S_FETCH;
      S_HALT:   if (run && !halt_req) state_next = S_FETCH;
      S_ERR:    state_next = S_ERR;
      default:  state_next = S_RST_HOLD;
    endcase
  end

  // State, counters and registered phase strobes decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_RST_HOLD;
      hold_cnt_reg  <= 8'd0;
      wait_cnt_reg  <= 8'd0;
      fetch_en_reg  <= 1'b0;
      decode_en_reg <= 1'b0;
      alu_start_reg <= 1'b0;
      mem_req_reg   <= 1'b0;
      commit_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      bus_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hold_cnt_reg  <= hold_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      fetch_en_reg  <= (state_next == S_FETCH);
      decode_en_reg <= (state_next == S_DECODE);
      alu_start_reg <= (state_next == S_EXEC) && (state_reg == S_DECODE);
      mem_req_reg   <= (state_next == S_MEM);
      commit_reg    <= (state_next == S_WB);
      busy_reg      <= (state_next >= S_FETCH) && (state_next <= S_WB);
      bus_err_reg   <= (state_next == S_ERR);
    end
  end

  assign state     = state_reg;
  assign fetch_en  = fetch_en_reg;
  assign decode_en = decode_en_reg;
  assign alu_start = alu_start_reg;
  assign mem_req   = mem_req_reg;
  assign commit    = commit_reg;
  assign busy      = busy_reg;
  assign bus_err   = bus_err_reg;

`ifdef PHASE_CTRL_PERF_EN
  logic [31:0] cycle_cnt_reg, instret_cnt_reg;

  // Performance counters; both wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_reg   <= 32'd0;
      instret_cnt_reg <= 32'd0;
    end else begin
      if (state_reg != S_RST_HOLD) cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      if (commit_reg)              instret_cnt_reg <= instret_cnt_reg + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_cnt_reg;
  assign instret_cnt = instret_cnt_reg;
`else
  assign cycle_cnt   = 32'd0;
  assign instret_cnt = 32'd0;
`endif

endmodule
